// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bundle between fetch_unit and the
// instruction memory.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the PC, fetches one word at a time over the
// imem handshake, and selects the next PC when the datapath retires.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               rst_n,
    fetch_unit_if.master       imem,
    output logic [31:0]        inst,
    output logic               inst_valid,
    output logic [31:0]        pc,
    output logic [31:0]        pc_plus4,
    input  logic               retire,
    input  logic               b_beq,
    input  logic               b_jal,
    input  logic               b_jalr,
    input  logic               zero,
    input  logic [31:0]        imm,
    input  logic [31:0]        rs1_data,
    output logic               misalign
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_VALID = 2'd2,
        ST_TRAP  = 2'd3
    } state_t;

    state_t      state_r;
    state_t      next_state_s;
    logic [31:0] pc_r;
    logic [31:0] pc_next_s;
    logic [31:0] inst_r;
    logic [31:0] inst_next_s;
    logic [31:0] jalr_sum_s;
    logic [31:0] target_s;

    // Branch target selection; jalr outranks jal, which outranks a taken beq.
    always_comb begin
        jalr_sum_s = rs1_data + imm;
        target_s   = pc_r + 32'd4;
        if (b_jalr) begin
            target_s = jalr_sum_s & ~32'h0000_0001;
        end else if (b_jal) begin
            target_s = pc_r + imm;
        end else if (b_beq && zero) begin
            target_s = pc_r + imm;
        end else begin
            target_s = pc_r + 32'd4;
        end
    end

    // Next-state, next-PC and instruction capture decode.
    always_comb begin
        next_state_s = state_r;
        pc_next_s    = pc_r;
        inst_next_s  = inst_r;
        case (state_r)
            ST_IDLE: begin
                next_state_s = ST_REQ;
            end
            ST_REQ: begin
                if (imem.imem_ready) begin
                    inst_next_s  = imem.imem_rdata;
                    next_state_s = ST_VALID;
                end else begin
                    next_state_s = ST_REQ;
                end
            end
            ST_VALID: begin
                if (retire) begin
                    // A misaligned target traps without moving the PC.
                    if (target_s[1:0] != 2'b00) begin
                        next_state_s = ST_TRAP;
                    end else begin
                        pc_next_s    = target_s;
                        next_state_s = ST_REQ;
                    end
                end else begin
                    next_state_s = ST_VALID;
                end
            end
            ST_TRAP: begin
                next_state_s = ST_TRAP;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State, PC and instruction registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            pc_r    <= RESET_PC;
            inst_r  <= NOP_INST;
        end else begin
            state_r <= next_state_s;
            pc_r    <= pc_next_s;
            inst_r  <= inst_next_s;
        end
    end

    assign imem.imem_req  = (state_r == ST_REQ);
    assign imem.imem_addr = pc_r;
    assign inst           = inst_r;
    assign inst_valid     = (state_r == ST_VALID);
    assign pc             = pc_r;
    assign pc_plus4       = pc_r + 32'd4;
    assign misalign       = (state_r == ST_TRAP);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: vector table of retire/branch cases with
// a fetch scoreboard, plus hand sequences for reset, trap and mid-fetch reset.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] inst;
    logic        inst_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        retire;
    logic        b_beq;
    logic        b_jal;
    logic        b_jalr;
    logic        zero;
    logic [31:0] imm;
    logic [31:0] rs1_data;
    logic        misalign;

    fetch_unit_if mem_if ();

    fetch_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem       (mem_if),
        .inst       (inst),
        .inst_valid (inst_valid),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .retire     (retire),
        .b_beq      (b_beq),
        .b_jal      (b_jal),
        .b_jalr     (b_jalr),
        .zero       (zero),
        .imm        (imm),
        .rs1_data   (rs1_data),
        .misalign   (misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        beq;
        logic        jal;
        logic        jalr;
        logic        zero;
        logic [31:0] imm;
        logic [31:0] rs1;
        logic [31:0] exp_pc;
        int          waits;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] word;
    } exp_t;

    exp_t        exp_q[$];
    vec_t        vecs[15];
    int          n_vec = 0;
    int          n_mis = 0;
    logic [31:0] last_word;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    task automatic clear_branch();
        retire   = 1'b0;
        b_beq    = 1'b0;
        b_jal    = 1'b0;
        b_jalr   = 1'b0;
        zero     = 1'b0;
        imm      = 32'h0;
        rs1_data = 32'h0;
    endtask

    // Pop the expected fetch, play memory with the given wait states, check result.
    task automatic do_fetch(input int waits);
        exp_t e;
        int   budget;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        budget = 0;
        while (mem_if.imem_req !== 1'b1 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        check("req_seen", {31'd0, mem_if.imem_req}, 32'd1);
        check("fetch_addr", mem_if.imem_addr, e.addr);
        check("inst_held", inst, last_word);
        check("valid_low_in_req", {31'd0, inst_valid}, 32'd0);
        for (int i = 0; i < waits; i++) begin
            retire = 1'b1;
            b_jal  = 1'b1;
            imm    = 32'h0000_1000;
            @(negedge clk);
            check("wait_req", {31'd0, mem_if.imem_req}, 32'd1);
            check("wait_addr", mem_if.imem_addr, e.addr);
            check("wait_inst", inst, last_word);
        end
        clear_branch();
        mem_if.imem_ready = 1'b1;
        mem_if.imem_rdata = e.word;
        @(negedge clk);
        mem_if.imem_ready = 1'b0;
        mem_if.imem_rdata = 32'hBAD0_BAD0;
        check("inst_valid", {31'd0, inst_valid}, 32'd1);
        check("inst", inst, e.word);
        check("pc", pc, e.addr);
        check("pc_plus4", pc_plus4, e.addr + 32'd4);
        last_word = e.word;
    endtask

    // Retire the current instruction with the vector's branch inputs.
    task automatic do_retire(input vec_t v);
        exp_t e;
        retire   = 1'b1;
        b_beq    = v.beq;
        b_jal    = v.jal;
        b_jalr   = v.jalr;
        zero     = v.zero;
        imm      = v.imm;
        rs1_data = v.rs1;
        e.addr   = v.exp_pc;
        e.word   = v.exp_pc ^ 32'h5A5A_0033;
        exp_q.push_back(e);
        @(negedge clk);
        clear_branch();
        do_fetch(v.waits);
    endtask

    initial begin
        exp_t e;
        //          beq   jal   jalr  zero  imm           rs1           exp_pc        waits
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0004, 0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0008, 3};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_000C, 0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0010, 0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'h0000_0000, 32'h0000_0014, 0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0010, 0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8, 32'h0000_0000, 32'h0000_0008, 0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0008, 32'h0000_0000, 32'h0000_0010, 1};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'h0000_0000, 32'h0000_0110, 0};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0201, 32'h0000_0200, 0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0011, 32'h0000_01F0, 32'h0000_0200, 0};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_000C, 32'hFFFF_FFF0, 32'hFFFF_FFFC, 0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 0};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0040, 32'h0000_0000, 32'h0000_0004, 0};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFF4, 32'h0000_0010, 32'h0000_0004, 0};

        rst_n = 1'b0;
        mem_if.imem_ready = 1'b0;
        mem_if.imem_rdata = 32'h0;
        clear_branch();
        last_word = NOP;
        repeat (2) @(negedge clk);
        check("rst_inst", inst, NOP);
        check("rst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_req", {31'd0, mem_if.imem_req}, 32'd0);
        check("rst_misalign", {31'd0, misalign}, 32'd0);
        check("rst_pc", pc, 32'h0);

        // First fetch: REQ appears in the cycle after the IDLE cycle.
        rst_n = 1'b1;
        @(negedge clk);
        check("first_req", {31'd0, mem_if.imem_req}, 32'd1);
        check("first_addr", mem_if.imem_addr, 32'h0);
        check("first_nop", inst, NOP);
        e.addr = 32'h0;
        e.word = 32'h0000_0033;
        exp_q.push_back(e);
        do_fetch(0);

        for (int i = 0; i < 15; i++) begin
            do_retire(vecs[i]);
        end

        // Misaligned jalr target traps and holds.
        retire   = 1'b1;
        b_jalr   = 1'b1;
        rs1_data = 32'h0000_0102;
        @(negedge clk);
        clear_branch();
        check("trap_misalign", {31'd0, misalign}, 32'd1);
        check("trap_req", {31'd0, mem_if.imem_req}, 32'd0);
        check("trap_valid", {31'd0, inst_valid}, 32'd0);
        check("trap_pc", pc, 32'h0000_0004);
        mem_if.imem_ready = 1'b1;
        retire = 1'b1;
        repeat (3) @(negedge clk);
        mem_if.imem_ready = 1'b0;
        retire = 1'b0;
        check("trap_hold", {31'd0, misalign}, 32'd1);
        check("trap_hold_req", {31'd0, mem_if.imem_req}, 32'd0);
        check("trap_hold_pc", pc, 32'h0000_0004);
        check("trap_hold_inst", inst, last_word);

        rst_n = 1'b0;
        @(negedge clk);
        check("trap_rst_misalign", {31'd0, misalign}, 32'd0);
        check("trap_rst_pc", pc, 32'h0);
        check("trap_rst_inst", inst, NOP);
        rst_n = 1'b1;
        last_word = NOP;
        e.addr = 32'h0;
        e.word = 32'h1111_0033;
        exp_q.push_back(e);
        do_fetch(0);

        // Reset while waiting on memory at 0x40; the late ready must be ignored.
        retire = 1'b1;
        b_jal  = 1'b1;
        imm    = 32'h0000_0040;
        @(negedge clk);
        clear_branch();
        check("mid_req", {31'd0, mem_if.imem_req}, 32'd1);
        check("mid_addr", mem_if.imem_addr, 32'h0000_0040);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        mem_if.imem_ready = 1'b1;
        mem_if.imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        mem_if.imem_ready = 1'b0;
        check("mid_rst_pc", pc, 32'h0);
        check("mid_rst_valid", {31'd0, inst_valid}, 32'd0);
        check("mid_rst_inst", inst, NOP);
        check("mid_rst_req", {31'd0, mem_if.imem_req}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_req", {31'd0, mem_if.imem_req}, 32'd1);
        check("post_rst_addr", mem_if.imem_addr, 32'h0);
        check("post_rst_inst", inst, NOP);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
